// File: rtl/mac_acc12_pkg.sv
// mac_acc12_pkg: shared constants and types for the mac_acc12 slice.
//   ACC_W / CNT_W : accumulator and term-counter widths
//   state_e       : 2-bit FSM encoding (ACCUM / DRAIN / OUT)
//   ACC_MAX/MIN   : signed clamp limits for the accumulator
package mac_acc12_pkg;

  localparam int ACC_W = 12;
  localparam int CNT_W = 4;
  localparam int OP_W  = 8;

  localparam logic [ACC_W-1:0] ACC_MAX = 12'h7FF;
  localparam logic [ACC_W-1:0] ACC_MIN = 12'h800;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

endpackage

// File: rtl/mac_acc12_sat_add.sv
// sat_add12: combinational signed add of an ACC_W accumulator and an 8-bit
// signed addend, clamped to the ACC_W signed range.
//   acc_i : current accumulator (signed)
//   add_i : 8-bit signed addend, sign-extended internally
//   sum_o : clamped sum
//   ovf_o : high when the clamp engaged
module sat_add12
  import mac_acc12_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [OP_W-1:0]  add_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [ACC_W:0] sum_w;

  // One guard bit: overflow whenever the top two bits of the widened sum differ.
  assign sum_w = {acc_i[ACC_W-1], acc_i} + {{(ACC_W+1-OP_W){add_i[OP_W-1]}}, add_i};

  always_comb begin
    sum_o = sum_w[ACC_W-1:0];
    ovf_o = 1'b0;
    if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
      ovf_o = 1'b1;
      // Guard bit carries the true sign of the unclamped result.
      sum_o = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/multi_s.sv
// multi_s: 8-bit signed multiplier, combinational.
//   a_i, b_i : signed operands
//   p_o      : low 8 bits of a_i*b_i (overflow is not flagged)
module multi_s (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  // The low 8 bits of a two's-complement product do not depend on the
  // operand signedness, so an 8-bit context multiply is exact here.
  assign p_o = a_i * b_i;

endmodule

// File: rtl/mac_acc12.sv
// mac_acc12: packet multiply-accumulate stage.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake, in_last marks the final term
//   a, b                : 8-bit signed operands
//   out_valid/out_ready : result handshake
//   out_acc             : saturated 12-bit signed packet sum
//   out_count           : accepted terms (saturating)
//   out_sat             : sticky clamp flag for the packet
//   dbg_state_o         : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; ready/valid outputs here decode only from registered state, and
// upstream holds its data until it sees in_ready.
module mac_acc12
  import mac_acc12_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output state_e           dbg_state_o
);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
  logic             v_q, v_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic             accept;
  logic [OP_W-1:0]  prod_w;
  logic [ACC_W-1:0] sum_w;
  logic             ovf_w;

  multi_s u_mul (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod_w)
  );

  sat_add12 u_add (
    .acc_i (acc_q),
    .add_i (prod_w),
    .sum_o (sum_w),
    .ovf_o (ovf_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      a_q     <= '0;
      b_q     <= '0;
      v_q     <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      v_q     <= v_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    v_d       = 1'b0;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_OUT);
    accept    = in_valid && in_ready;

    // Stage 2: the pair registered last cycle lands in the accumulator.
    // In DRAIN this is the final term; v_q is never set while in OUT.
    if (v_q) begin
      acc_d = sum_w;
      sat_d = sat_q | ovf_w;
    end

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          a_d = a;
          b_d = b;
          v_d = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (in_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  assign out_acc     = acc_q;
  assign out_count   = cnt_q;
  assign out_sat     = sat_q;
  assign dbg_state_o = state_q;

endmodule
